// File: rtl/pb_queue_ctrl.sv
// Packet buffer ring controller: ingress write addressing with commit/drop/abort,
// egress one-frame-at-a-time transmit scheduling with an inter-frame gap.
module pb_queue_ctrl #(
    parameter int unsigned PART_LEN_LOG2  = 10,
    parameter int unsigned QUEUE_LEN_LOG2 = 3,
    parameter int unsigned FRAME_LEN      = 1000,
    parameter int unsigned IFG_CYCLES     = 48
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_abort,
    input  logic                                    wr_en,
    input  logic [7:0]                              wr_data,
    output logic                                    ram_we,
    output logic [PART_LEN_LOG2+QUEUE_LEN_LOG2-1:0] ram_waddr,
    output logic [7:0]                              ram_win,
    output logic                                    tx_start,
    output logic [PART_LEN_LOG2+QUEUE_LEN_LOG2-1:0] tx_read_start,
    output logic [PART_LEN_LOG2+QUEUE_LEN_LOG2-1:0] tx_read_end,
    input  logic                                    tx_done,
    output logic                                    tx_active,
    output logic [QUEUE_LEN_LOG2-1:0]               count,
    output logic                                    empty,
    output logic                                    full,
    output logic [15:0]                             drop_cnt
);

    localparam int unsigned PW       = PART_LEN_LOG2;
    localparam int unsigned QW       = QUEUE_LEN_LOG2;
    localparam int unsigned AW       = PART_LEN_LOG2 + QUEUE_LEN_LOG2;
    localparam int unsigned DW       = 16;
    localparam int unsigned GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   head_q, head_d;
    logic [QW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [DW-1:0]   drop_q, drop_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            tx_start_q, tx_start_d;
    logic            frame_last;

    // Write path is combinational so each byte lands in RAM on the cycle it arrives.
    assign ram_we     = wr_en & ~wr_abort & ~rst;
    assign ram_waddr  = {tail_q, wr_cnt_q};
    assign ram_win    = wr_data;
    assign frame_last = (wr_cnt_q == PW'(FRAME_LEN - 1));

    assign count = QW'(tail_q - head_q);
    assign empty = (head_q == tail_q);
    assign full  = (QW'(tail_q + QW'(1)) == head_q);

    assign tx_read_start = {head_q, PW'(0)};
    assign tx_read_end   = AW'(tx_read_start + AW'(FRAME_LEN));
    assign tx_start      = tx_start_q;
    assign tx_active     = (state_q == S_START) || (state_q == S_ACTIVE);
    assign drop_cnt      = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            wr_cnt_q   <= '0;
            drop_q     <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_q     <= drop_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        wr_cnt_d   = wr_cnt_q;
        drop_d     = drop_q;
        gap_d      = gap_q;
        tx_start_d = (state_q == S_START);

        // Ingress: abort discards the partial frame; a full ring recycles the tail partition.
        if (wr_abort) begin
            wr_cnt_d = '0;
        end else if (wr_en) begin
            if (frame_last) begin
                wr_cnt_d = '0;
                if (!full) begin
                    tail_d = QW'(tail_q + QW'(1));
                end else if (drop_q != {DW{1'b1}}) begin
                    drop_d = DW'(drop_q + DW'(1));
                end
            end else begin
                wr_cnt_d = PW'(wr_cnt_q + PW'(1));
            end
        end

        // Egress scheduler
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (tx_done) begin
                    head_d = QW'(head_q + QW'(1));
                    gap_d  = '0;
                    state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = GW'(gap_q + GW'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
